// File: rtl/imm_ext_ctrl_if.sv
// Instruction-in / operand-out handshake bundle for the decode immediate sequencer.
interface imm_ext_ctrl_if #(
    parameter int KIND_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [31:0]       in_pc4;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_imm;
    logic [KIND_W-1:0] out_kind;
    logic [31:0]       out_pc4;

    modport slave (
        input  in_valid, in_instr, in_pc4, out_ready,
        output in_ready, out_valid, out_imm, out_kind, out_pc4
    );

    modport master (
        output in_valid, in_instr, in_pc4, out_ready,
        input  in_ready, out_valid, out_imm, out_kind, out_pc4
    );
endinterface

// File: rtl/imm_ext_ctrl.sv
// Decode-stage immediate builder with a 2-entry skid FIFO toward execute.
// Optional stall statistics counter enabled by IMM_STALL_CNT_EN.
module imm_ext_ctrl #(
    parameter int DEPTH  = 2,
    parameter int KIND_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_ext_ctrl_if.slave bus,
    output logic [15:0]   stall_cnt
);
    if (DEPTH != 2) begin : g_depth_chk
        $error("imm_ext_ctrl supports DEPTH=2 only");
    end

    localparam logic [KIND_W-1:0] K_NONE  = KIND_W'(0);
    localparam logic [KIND_W-1:0] K_SEXT  = KIND_W'(1);
    localparam logic [KIND_W-1:0] K_ZEXT  = KIND_W'(2);
    localparam logic [KIND_W-1:0] K_LUI   = KIND_W'(3);
    localparam logic [KIND_W-1:0] K_SHAMT = KIND_W'(4);
    localparam logic [KIND_W-1:0] K_JUMP  = KIND_W'(5);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_in_ready;
    logic [31:0]       r_h_imm;
    logic [KIND_W-1:0] r_h_kind;
    logic [31:0]       r_h_pc4;
    logic [31:0]       r_t_imm;
    logic [KIND_W-1:0] r_t_kind;
    logic [31:0]       r_t_pc4;

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [31:0]       w_imm;
    logic [KIND_W-1:0] w_kind;
    logic              w_acc;
    logic              w_pop;
    logic              w_out_valid;
    logic              w_ld_head_new;
    logic              w_ld_head_tail;
    logic              w_ld_tail;

    assign w_op    = bus.in_instr[31:26];
    assign w_funct = bus.in_instr[5:0];

    always_comb begin
        w_kind = K_NONE;
        w_imm  = 32'h0;
        case (w_op)
            6'h00: begin
                if (w_funct == 6'h00 || w_funct == 6'h02 ||
                    w_funct == 6'h03) begin
                    w_kind = K_SHAMT;
                    w_imm  = {27'b0, bus.in_instr[10:6]};
                end
            end
            6'h04, 6'h05, 6'h08, 6'h09,
            6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                w_kind = K_SEXT;
                w_imm  = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_kind = K_ZEXT;
                w_imm  = {16'b0, bus.in_instr[15:0]};
            end
            6'h0F: begin
                w_kind = K_LUI;
                w_imm  = {bus.in_instr[15:0], 16'b0};
            end
            6'h02, 6'h03: begin
                w_kind = K_JUMP;
                w_imm  = {bus.in_pc4[31:28], bus.in_instr[25:0], 2'b00};
            end
            default: begin
                w_kind = K_NONE;
                w_imm  = 32'h0;
            end
        endcase
    end

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_acc       = bus.in_valid & r_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    // Flush overrides every transition; a simultaneous pop still completes downstream.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_head_new  = 1'b0;
        w_ld_head_tail = 1'b0;
        w_ld_tail      = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt   = S_ONE;
                        w_ld_head_new = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_acc && !w_pop) begin
                        w_state_nxt = S_TWO;
                        w_ld_tail   = 1'b1;
                    end else if (w_pop && !w_acc) begin
                        w_state_nxt = S_EMPTY;
                    end else if (w_acc && w_pop) begin
                        w_ld_head_new = 1'b1;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_state_nxt    = S_ONE;
                        w_ld_head_tail = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_imm  <= 32'h0;
            r_h_kind <= K_NONE;
            r_h_pc4  <= 32'h0;
            r_t_imm  <= 32'h0;
            r_t_kind <= K_NONE;
            r_t_pc4  <= 32'h0;
        end else begin
            if (w_ld_head_new) begin
                r_h_imm  <= w_imm;
                r_h_kind <= w_kind;
                r_h_pc4  <= bus.in_pc4;
            end else if (w_ld_head_tail) begin
                r_h_imm  <= r_t_imm;
                r_h_kind <= r_t_kind;
                r_h_pc4  <= r_t_pc4;
            end
            if (w_ld_tail) begin
                r_t_imm  <= w_imm;
                r_t_kind <= w_kind;
                r_t_pc4  <= bus.in_pc4;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_imm   = r_h_imm;
    assign bus.out_kind  = r_h_kind;
    assign bus.out_pc4   = r_h_pc4;

`ifdef IMM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0;
        end else if (w_out_valid && !bus.out_ready &&
                     r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'h1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0;
`endif
endmodule

// File: doc/imm_ext_ctrl.md
Name: imm_ext_ctrl

Overview:
Decode-stage immediate sequencer for the MIPS core. It accepts instruction words over a valid/ready handshake, classifies each opcode, and builds the 32-bit operand: sign-extended IMM16, zero-extended IMM16, LUI, zero-extended SHAMT, or jump target. Results are buffered in a 2-entry skid FIFO toward the execute stage, with stall and flush support.

Parameters:
DEPTH, 2, buffer entries; fixed at 2; other values unsupported.
KIND_W, 3, width of operand-kind code.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
flush  input  1  synchronous flush; discards all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept an instruction this cycle
in_instr  input  32  instruction word
in_pc4  input  32  PC+4 of the instruction
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head entry
out_imm  output  32  extended operand of head entry
out_kind  output  3  0 NONE, 1 SEXT, 2 ZEXT, 3 LUI, 4 SHAMT, 5 JUMP
out_pc4  output  32  PC+4 carried with head entry
stall_cnt  output  16  stall statistics (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): buffer EMPTY; out_valid=0, in_ready=1 on release, out_imm=0, out_kind=0, out_pc4=0, stall_cnt=0.
- Decode (combinational on input, registered into buffer). op=in_instr[31:26]:
  - op=0, funct in {0,2,3} (sll/srl/sra) -> SHAMT, imm={27'b0,instr[10:6]}.
  - op=0, any other funct -> NONE, imm=0.
  - op in {0x08,0x09,0x0A,0x0B,0x04,0x05,0x23,0x2B} -> SEXT, imm={{16{instr[15]}},instr[15:0]}.
  - op in {0x0C,0x0D,0x0E} -> ZEXT, imm={16'b0,instr[15:0]}.
  - op=0x0F -> LUI, imm={instr[15:0],16'b0}.
  - op in {0x02,0x03} -> JUMP, imm={in_pc4[31:28],instr[25:0],2'b00}.
  - All other opcodes -> NONE, imm=0.
- States: EMPTY (0 entries), ONE (1), TWO (2, full). in_ready=(state!=TWO), driven from a register, never combinationally from out_ready.
- Accept = in_valid&in_ready; pop = out_valid&out_ready.
- Latency: instruction accepted in cycle N appears at the output in cycle N+1 if the buffer was EMPTY.
- EMPTY: accept -> ONE.
- ONE: accept&!pop -> TWO; pop&!accept -> EMPTY; accept&pop -> ONE, new entry at head; neither -> hold.
- TWO: pop -> ONE, second entry moves to head; no accept is possible.
- Ordering is strict FIFO. The head holds stable while out_valid&!out_ready.
- flush: next state EMPTY and out_valid=0 next cycle. A same-cycle accept is dropped. A same-cycle pop completes downstream, but the entry is not re-presented. Flush has priority over all transitions.
- Reset asserted mid-transfer: all entries discarded immediately.

Optional Feature:
- Macro IMM_STALL_CNT_EN.
- Defined: stall_cnt increments on each cycle with out_valid&!out_ready and saturates at 0xFFFF. It clears on reset only; flush does not clear it.
- Undefined: no counter logic; stall_cnt tied to 0.

Test Plan:
- addi, instr=0x2008FFFC, out_ready=1 -> next cycle out_kind=1, out_imm=0xFFFFFFFC; ori 0x3508ABCD -> kind 2, imm=0x0000ABCD.
- lui 0x3C081234 -> kind 3, imm=0x12340000; sll with shamt 31 (0x000847C0) -> kind 4, imm=0x0000001F; add (0x01095020) -> kind 0, imm=0.
- j 0x08000010 with in_pc4=0xA0000004 -> kind 5, imm=0xA0000040.
- out_ready=0, three back-to-back valid inputs -> two accepted, in_ready=0 after the second, head stable. Raise out_ready -> FIFO order preserved. With IMM_STALL_CNT_EN, stall_cnt equals the count of held cycles.
- Buffer TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped.
- Buffer ONE, rst_n pulsed low mid-cycle -> out_valid=0 immediately, stall_cnt=0.
